keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad (Pmod KYPD style), debounces and decodes one key at a time into a hex code, and shifts accepted digits into a 32-bit entry buffer. It is the input-side counterpart of the 8-digit display driver: `entry[31:0]` connects directly to the display's `data` input, so the newest key appears on the rightmost digit. It sits between the keypad Pmod pins and the top-level datapath.

## Interface
- `SCAN_DIV`, 100000: clk cycles each column is driven low (1 ms at 100 MHz). Must be ≥4.
- `DEBOUNCE_SCANS`, 20: consecutive identical full scans required to accept a press or a release. Must be ≥2.
- `clk`  in  1  100 MHz system clock.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `row`  in  4  keypad row lines, active-low, pulled up externally, asynchronous to `clk`.
- `clr`  in  1  synchronous clear of `entry`.
- `col`  out  4  column drive, active-low, exactly one bit low at any time.
- `key_code`  out  4  hex code of the last accepted key; holds until the next accept.
- `key_valid`  out  1  one-cycle pulse when a key press is accepted.
- `key_pressed`  out  1  level; high from accept until the release is debounced.
- `entry`  out  32  last 8 accepted codes; `entry[3:0]` is the newest.

## Operation
- Synchronize `row` through two flops before any use.
- Slot counter counts 0..SCAN_DIV-1. On wrap, the column advances col0→col1→col2→col3→col0, with `col` = 1110, 1101, 1011, 0111 respectively.
- Sample the synchronized row in the cycle where slot counter = SCAN_DIV-1, before the column changes.
- Accumulate one full scan (col0..col3 samples). At the end of the col3 slot, issue a one-cycle `scan_done` strobe with a raw result:
  - NONE: no low row bit seen.
  - SINGLE(code): exactly one low bit across all 4 samples.
  - MULTI: two or more low bits. MULTI is treated as NONE for press detection and as "not NONE" for release detection.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce FSM state and the counter `cnt` update only on `scan_done`:
  - IDLE
    - SINGLE(k) → PRESS_CHK, with `cand`=k and `cnt`=1.
  - PRESS_CHK
    - SINGLE(cand): increment `cnt`. When `cnt` reaches DEBOUNCE_SCANS: `key_code`←cand, pulse `key_valid`, `key_pressed`←1, go to HELD.
    - Any other result → IDLE.
  - HELD
    - NONE → RELEASE_CHK, with `cnt`=1.
    - Any other result → stay. A second key pressed while held is ignored.
  - RELEASE_CHK
    - NONE: increment `cnt`. When `cnt` reaches DEBOUNCE_SCANS: `key_pressed`←0, go to IDLE.
    - Anything else → HELD.
- Entry buffer:
  - When `key_valid` is high: `entry` ← {entry[27:0], key_code}. The oldest digit is discarded (wrap-around).
  - When `clr` is high: `entry` ← 0. `clr` wins over a simultaneous `key_valid`; that key is dropped from `entry`, but `key_valid` and `key_code` still update.
- Reset values:
  - `col`=1110; slot counter, `cnt` and scan accumulator = 0; FSM = IDLE.
  - `key_code`=0, `key_valid`=0, `key_pressed`=0, `entry`=0.
- Reset mid-press: all state returns to reset values. A key still held after reset must pass a full debounce again before it is reported.

## Timing
- Scan period = 4·SCAN_DIV cycles. `col` changes in the cycle after slot counter = SCAN_DIV-1.
- Row settle margin = SCAN_DIV-1 cycles minus the 2-cycle synchronizer delay.
- `scan_done` occurs in the cycle after the col3 sample.
- `key_valid`, `key_code` and `key_pressed` are registered and change in the cycle after the `scan_done` that reaches the threshold.
- `entry` updates one cycle after `key_valid` is high.
- Press latency: a key that is stable before a scan starts is accepted at the end of scan DEBOUNCE_SCANS.
- Release latency: `key_pressed` falls at the end of the DEBOUNCE_SCANS-th empty scan.
- At most one `key_valid` pulse per press/release cycle.

## Test plan
Use `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=3.
- Reset, then run free → all outputs at reset values; `col` steps 1110→1101→1011→0111→1110 every 4 cycles.
- Hold row1 low while col1 is low for 6 scans, then release → exactly one `key_valid` with `key_code`=5 after scan 3; `key_pressed`=1; `entry`=0x00000005; `key_pressed`=0 after 3 empty scans.
- Bounce key 9: 2 scans pressed, 1 released, 2 pressed, then release → no `key_valid`; `entry` unchanged.
- Press keys 1 and 2 together for 5 scans → MULTI, no `key_valid`. Then press 4, and while it is held add 7 → one `key_valid`, code 4 only.
- Enter keys 1,2,3,A,B,C,D,E,F sequentially → `entry`=0x23ABCDEF (oldest dropped).
- Assert `clr` in the cycle `key_valid` is high for key 8 → `entry`=0, `key_code`=8. Assert `rst_n` low mid-PRESS_CHK while still holding the key → outputs reset; after release, a new `key_valid` requires 3 clean scans.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with scan-level debounce.
// Accepted key codes shift into a 32-bit entry buffer.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_pressed,
  output logic [31:0] entry
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] THR  = CW'(DEBOUNCE_SCANS);
  // nibble {row,col} holds the legend of that key
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  typedef enum logic [1:0] {
    IDLE, PRESS_CHK, HELD, RELEASE_CHK
  } state_e;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic [1:0]    res_cnt_q, res_cnt_d;
  logic [3:0]    res_code_q, res_code_d;
  logic          done_q, done_d;
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_pressed_q, key_pressed_d;
  logic [31:0]   entry_q, entry_d;

  logic [2:0]    n_low, sum;
  logic [1:0]    r_idx, cur_cnt;
  logic [3:0]    cur_code;
  logic          sample;

  always_comb begin
    slot_d    = (slot_q == LAST) ? '0 : slot_q + 1'b1;
    col_idx_d = (slot_q == LAST) ? col_idx_q + 2'd1 : col_idx_q;
  end

  always_comb begin
    n_low = '0;
    r_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2_q[i]) begin
        n_low = n_low + 3'd1;
        r_idx = 2'(i);
      end
    end
    sum = {1'b0, acc_cnt_q} + ((n_low > 3'd2) ? 3'd2 : n_low);
    cur_cnt = (sum > 3'd2) ? 2'd2 : sum[1:0];
    cur_code = acc_code_q;
    if (acc_cnt_q == 2'd0 && n_low == 3'd1)
      cur_code = KEYMAP[{r_idx, col_idx_q, 2'b00} +: 4];
    sample     = (slot_q == LAST);
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    res_cnt_d  = res_cnt_q;
    res_code_d = res_code_q;
    done_d     = 1'b0;
    if (sample) begin
      if (col_idx_q == 2'd3) begin
        res_cnt_d  = cur_cnt;
        res_code_d = cur_code;
        done_d     = 1'b1;
        acc_cnt_d  = '0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = cur_cnt;
        acc_code_d = cur_code;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    if (done_q) begin
      unique case (state_q)
        IDLE: begin
          if (res_cnt_q == 2'd1) begin
            state_d = PRESS_CHK;
            cand_d  = res_code_q;
            cnt_d   = CW'(1);
          end
        end
        PRESS_CHK: begin
          if (res_cnt_q == 2'd1 && res_code_q == cand_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == THR) begin
              key_code_d    = cand_q;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
              state_d       = HELD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (res_cnt_q == 2'd0) begin
            state_d = RELEASE_CHK;
            cnt_d   = CW'(1);
          end
        end
        RELEASE_CHK: begin
          if (res_cnt_q == 2'd0) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == THR) begin
              key_pressed_d = 1'b0;
              state_d       = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // clear beats a same-cycle accept; the key still shows on key_code
  always_comb begin
    entry_d = entry_q;
    if (clr)
      entry_d = '0;
    else if (key_valid_q)
      entry_d = {entry_q[27:0], key_code_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q      <= 4'hF;
      row_s2_q      <= 4'hF;
      slot_q        <= '0;
      col_idx_q     <= '0;
      acc_cnt_q     <= '0;
      acc_code_q    <= '0;
      res_cnt_q     <= '0;
      res_code_q    <= '0;
      done_q        <= 1'b0;
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      entry_q       <= '0;
    end else begin
      row_s1_q      <= row;
      row_s2_q      <= row_s1_q;
      slot_q        <= slot_d;
      col_idx_q     <= col_idx_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      res_cnt_q     <= res_cnt_d;
      res_code_q    <= res_code_d;
      done_q        <= done_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
      entry_q       <= entry_d;
    end
  end

  assign col         = ~(4'b0001 << col_idx_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;
  assign entry       = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Uses SCAN_DIV=4, DEBOUNCE_SCANS=3 (one scan = 16 cycles).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [31:0] entry;

  logic [15:0] keys;
  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int snap;
  int seq [9] = '{0, 1, 2, 3, 7, 11, 15, 14, 13};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .clr(clr),
    .col(col), .key_code(key_code), .key_valid(key_valid),
    .key_pressed(key_pressed), .entry(entry)
  );

  always #5 clk = ~clk;

  // key bit r*4+c pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) if (key_valid === 1'b1) nvalid++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // return just after the edge that starts a new scan (col0)
  task automatic align();
    logic [3:0] p;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      p = col;
      @(posedge clk);
      #1;
      ok = (p == 4'b0111 && col == 4'b1110);
    end
    chk("align", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    keys  = '0;
    cyc(3);
    chk("rst_col", {28'd0, col}, 32'hE);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_pressed", {31'd0, key_pressed}, 32'd0);
    chk("rst_entry", entry, 32'h0);
    rst_n = 1'b1;
    cyc(4);
    chk("col1", {28'd0, col}, 32'hD);
    cyc(4);
    chk("col2", {28'd0, col}, 32'hB);
    cyc(4);
    chk("col3", {28'd0, col}, 32'h7);
    cyc(4);
    chk("col0_wrap", {28'd0, col}, 32'hE);

    // key 5: accept after scan 3, release after 3 empty scans
    align();
    snap = nvalid;
    keys = 16'h0020;
    cyc(48);
    chk("k5_pre_valid", {31'd0, key_valid}, 32'd0);
    chk("k5_pre_pressed", {31'd0, key_pressed}, 32'd0);
    cyc(1);
    chk("k5_valid", {31'd0, key_valid}, 32'd1);
    chk("k5_code", {28'd0, key_code}, 32'h5);
    chk("k5_pressed", {31'd0, key_pressed}, 32'd1);
    cyc(1);
    chk("k5_valid_pulse", {31'd0, key_valid}, 32'd0);
    chk("k5_entry", entry, 32'h5);
    cyc(46);
    align();
    keys = '0;
    cyc(48);
    chk("k5_rel_hold", {31'd0, key_pressed}, 32'd1);
    cyc(1);
    chk("k5_rel", {31'd0, key_pressed}, 32'd0);
    chk("k5_count", nvalid - snap, 32'd1);

    // bounce on key 9
    align();
    snap = nvalid;
    keys = 16'h0400;
    cyc(32);
    keys = '0;
    cyc(16);
    keys = 16'h0400;
    cyc(32);
    keys = '0;
    cyc(80);
    chk("bounce_count", nvalid - snap, 32'd0);
    chk("bounce_entry", entry, 32'h5);
    chk("bounce_pressed", {31'd0, key_pressed}, 32'd0);

    // keys 1+2 together, then 4 held with 7 added
    snap = nvalid;
    keys = 16'h0003;
    cyc(80);
    chk("multi_count", nvalid - snap, 32'd0);
    chk("multi_pressed", {31'd0, key_pressed}, 32'd0);
    keys = '0;
    cyc(32);
    align();
    keys = 16'h0010;
    cyc(49);
    chk("k4_valid", {31'd0, key_valid}, 32'd1);
    chk("k4_code", {28'd0, key_code}, 32'h4);
    keys = 16'h0110;
    cyc(48);
    chk("k47_count", nvalid - snap, 32'd1);
    chk("k47_code", {28'd0, key_code}, 32'h4);
    chk("k47_pressed", {31'd0, key_pressed}, 32'd1);
    keys = '0;
    cyc(72);
    chk("k47_rel", {31'd0, key_pressed}, 32'd0);
    chk("k47_entry", entry, 32'h54);

    // nine digits: oldest fall off the top
    snap = nvalid;
    foreach (seq[i]) begin
      align();
      keys = 16'(1) << seq[i];
      cyc(56);
      keys = '0;
      cyc(72);
    end
    chk("seq_count", nvalid - snap, 32'd9);
    chk("seq_entry", entry, 32'h23AB_CDEF);
    chk("seq_code", {28'd0, key_code}, 32'hF);

    // clr in the key_valid cycle of key 8
    align();
    keys = 16'h0200;
    cyc(49);
    chk("k8_valid", {31'd0, key_valid}, 32'd1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_entry", entry, 32'h0);
    chk("clr_code", {28'd0, key_code}, 32'h8);
    keys = '0;
    cyc(72);

    // reset during PRESS_CHK with key 6 held
    align();
    keys = 16'h0040;
    cyc(33);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", {28'd0, col}, 32'hE);
    chk("mid_rst_code", {28'd0, key_code}, 32'h0);
    chk("mid_rst_pressed", {31'd0, key_pressed}, 32'd0);
    chk("mid_rst_entry", entry, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    snap = nvalid;
    cyc(48);
    chk("post_rst_novalid", nvalid - snap, 32'd0);
    chk("post_rst_pressed0", {31'd0, key_pressed}, 32'd0);
    cyc(1);
    chk("post_rst_valid", {31'd0, key_valid}, 32'd1);
    chk("post_rst_code", {28'd0, key_code}, 32'h6);
    cyc(1);
    chk("post_rst_entry", entry, 32'h6);
    keys = '0;
    cyc(72);
    chk("post_rst_rel", {31'd0, key_pressed}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
